branch_resolve: RTL and testbench
=================================

# branch_resolve

Execute-stage branch resolution unit, directly downstream of the branch comparator. Combines the comparator's condition bit with the instruction's jump/branch class and the fetch-stage prediction, computes the actual next PC, and on mispredict issues a registered one-cycle PC redirect plus a multi-cycle flush of the younger pipeline stages. Also raises an instruction-address-misaligned trap for taken targets that are not 4-byte aligned.

## Interface
- `XLEN`, 32: datapath width
- `FLUSH_CYCLES`, 2: cycles `flush` is held (≥1); equals the number of stages younger than EX
- `CNT_W`, 32: width of the statistics counters

- `clk` in 1: clock
- `rst` in 1: reset, asynchronous, active-high
- `ex_valid` in 1: valid instruction in EX
- `stall_in` in 1: EX held this cycle; no resolution occurs
- `ex_is_branch` in 1: conditional branch
- `ex_is_jump` in 1: JAL or JALR
- `ex_is_jalr` in 1: JALR (qualifies `ex_is_jump`)
- `cmp_out` in XLEN: comparator result; only bit 0 used
- `ex_pc` in XLEN: PC of EX instruction
- `ex_imm` in XLEN: sign-extended offset
- `ex_rs1` in XLEN: rs1 value for JALR
- `ex_pred_taken` in 1: fetch predicted taken
- `ex_pred_target` in XLEN: fetch predicted target
- `redirect_valid` out 1: one-cycle redirect strobe
- `redirect_pc` out XLEN: corrected fetch PC, valid with `redirect_valid`
- `flush` out 1: squash IF/ID (younger stages)
- `trap_misaligned` out 1: one-cycle misaligned-target trap strobe
- `trap_tval` out XLEN: offending target, valid with `trap_misaligned`
- `branch_cnt` out CNT_W: resolved control transfers (macro only)
- `mispredict_cnt` out CNT_W: mispredicts (macro only)

## Operation
- Resolve event: state IDLE && `ex_valid` && !`stall_in` && (`ex_is_branch` | `ex_is_jump`).
- taken = `ex_is_jump` | (`ex_is_branch` & `cmp_out[0]`).
- target = `ex_is_jalr` ? ((`ex_rs1`+`ex_imm`) & ~1) : (`ex_pc`+`ex_imm`); fallthrough = `ex_pc`+4; all sums modulo 2^XLEN (wrap, no carry out).
- misaligned = taken && target[1].
- mispredict = (taken != `ex_pred_taken`) || (taken && `ex_pred_target` != target).
- States: IDLE, REDIRECT, SQUASH.
  - IDLE → REDIRECT on resolve event with mispredict or misaligned; registers redirect_pc = taken ? target : fallthrough, trap_tval = target.
  - REDIRECT: `flush`=1; `redirect_valid`=1 unless misaligned, in which case `trap_misaligned`=1 and `redirect_valid`=0. → IDLE if FLUSH_CYCLES==1, else → SQUASH with squash counter = FLUSH_CYCLES-2.
  - SQUASH: `flush`=1; counter decrements; → IDLE when counter is 0.
- In REDIRECT/SQUASH all EX inputs are wrong-path and ignored (no resolve, no counting), regardless of `stall_in`.
- Correctly predicted, aligned transfers: no outputs asserted.
- Non-control instructions and `ex_valid`=0: ignored.

## Timing
- Resolve sampled at edge ending cycle N; `redirect_valid`/`trap_misaligned` high in N+1 only; `flush` high N+1 .. N+FLUSH_CYCLES.
- Earliest next resolve: cycle N+FLUSH_CYCLES+1.
- All outputs registered; no combinational path input → output.
- Reset: state IDLE, every output 0 (including `redirect_pc`, `trap_tval`, counters). `rst` mid-REDIRECT/SQUASH drops `flush` immediately (async) and returns to IDLE.

## Configuration
- `BRANCH_STATS_EN` defined: `branch_cnt` increments on every resolve event, `mispredict_cnt` on every resolve with mispredict (misaligned-only does not count); both wrap at 2^CNT_W; both increment in the same edge when applicable.
- Undefined: both ports and counters absent; all other behaviour identical.

## Structure
- `branch_pkg`: state enum typedef (IDLE/REDIRECT/SQUASH), `FLUSH_CYCLES` default, constant 4 for fallthrough increment.
- Sub-module `branch_target_gen`: combinational target/fallthrough/misaligned computation; FSM, registers and counters in `branch_resolve`.

## Test plan
- BEQ, pc=0x100, imm=0x20, cmp_out=1, pred_taken=0 → N+1 `redirect_valid`=1, `redirect_pc`=0x120; `flush` high N+1..N+2.
- BNE, pc=0x200, cmp_out=0, pred_taken=1 → `redirect_pc`=0x204; same-target correct prediction (pred_taken=1, pred_target=0x120 on first case) → no strobes.
- JALR rs1=0x1001, imm=0x10 → target 0x1010 (bit0 cleared); JAL pc=0x100, imm=0x2 → `trap_misaligned`=1, `trap_tval`=0x102, `redirect_valid`=0.
- Mispredict followed by back-to-back mispredicting branches in N+1, N+2 → ignored; next resolve accepted in N+3; `stall_in`=1 with mispredict → no response until released.
- pc=0xFFFF_FFFC, not-taken mispredict → `redirect_pc`=0x0000_0000; `rst` pulse during SQUASH → `flush`=0 immediately, all outputs 0.
- With `BRANCH_STATS_EN`: 10 branches, 3 mispredicts, 1 misaligned → `branch_cnt`=10, `mispredict_cnt`=3; counter preset near 2^CNT_W-1 wraps to 0.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared types and constants for the execute-stage branch resolution unit.
package branch_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_REDIRECT = 2'd1;
  localparam state_t ST_SQUASH   = 2'd2;

  localparam int unsigned XLEN_DEF         = 32;
  localparam int unsigned FLUSH_CYCLES_DEF = 2;
  localparam int unsigned CNT_W_DEF        = 32;
  localparam int unsigned PC_INCR          = 4;

endpackage

// File: rtl/branch_target_gen.sv
// Combinational target, fallthrough and misalignment computation for a resolving
// branch/jump. All sums wrap modulo 2^XLEN.
module branch_target_gen
  import branch_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic            is_branch,
  input  logic            is_jump,
  input  logic            is_jalr,
  input  logic            cmp_bit,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  output logic            taken_c,
  output logic [XLEN-1:0] target_c,
  output logic [XLEN-1:0] fallthrough_c,
  output logic            misaligned_c
);

  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] pc_rel_sum;

  always_comb begin
    jalr_sum      = rs1 + imm;
    pc_rel_sum    = pc + imm;
    taken_c       = is_jump | (is_branch & cmp_bit);
    // JALR clears bit 0 of its target; bit 1 is still allowed to be misaligned
    target_c      = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : pc_rel_sum;
    fallthrough_c = pc + XLEN'(PC_INCR);
    misaligned_c  = taken_c & target_c[1];
  end

endmodule

// File: rtl/branch_resolve.sv
// Execute-stage branch resolution: registered PC redirect, younger-stage flush and
// misaligned-target trap. Optional statistics counters under BRANCH_STATS_EN.
module branch_resolve
  import branch_pkg::*;
#(
  parameter int unsigned XLEN         = XLEN_DEF,
  parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic            stall_in,
  input  logic            ex_is_branch,
  input  logic            ex_is_jump,
  input  logic            ex_is_jalr,
  input  logic [XLEN-1:0] cmp_out,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic            trap_misaligned,
  output logic [XLEN-1:0] trap_tval
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
`endif
);

  localparam int unsigned SQ_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES - 1) : 1;

  logic            taken_c;
  logic            misaligned_c;
  logic            mispredict_c;
  logic            resolve_c;
  logic [XLEN-1:0] target_c;
  logic [XLEN-1:0] fallthrough_c;
  logic            unused_cmp_hi;

  state_t          state_q, state_d;
  logic [SQ_W-1:0] sq_cnt_q, sq_cnt_d;
  logic            redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            flush_q, flush_d;
  logic            trap_q, trap_d;
  logic [XLEN-1:0] trap_tval_q, trap_tval_d;

  assign unused_cmp_hi = ^cmp_out[XLEN-1:1];

  branch_target_gen #(.XLEN(XLEN)) u_target_gen (
    .is_branch     (ex_is_branch),
    .is_jump       (ex_is_jump),
    .is_jalr       (ex_is_jalr),
    .cmp_bit       (cmp_out[0]),
    .pc            (ex_pc),
    .imm           (ex_imm),
    .rs1           (ex_rs1),
    .taken_c       (taken_c),
    .target_c      (target_c),
    .fallthrough_c (fallthrough_c),
    .misaligned_c  (misaligned_c)
  );

  // Wrong-path instructions in REDIRECT/SQUASH never resolve.
  assign resolve_c    = (state_q == ST_IDLE) & ex_valid & ~stall_in & (ex_is_branch | ex_is_jump);
  assign mispredict_c = (taken_c != ex_pred_taken) | (taken_c & (ex_pred_target != target_c));

  always_comb begin
    state_d          = state_q;
    sq_cnt_d         = sq_cnt_q;
    redirect_valid_d = 1'b0;
    trap_d           = 1'b0;
    flush_d          = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    trap_tval_d      = trap_tval_q;
    case (state_q)
      ST_IDLE: begin
        if (resolve_c && (mispredict_c || misaligned_c)) begin
          state_d          = ST_REDIRECT;
          flush_d          = 1'b1;
          redirect_valid_d = ~misaligned_c;
          trap_d           = misaligned_c;
          redirect_pc_d    = taken_c ? target_c : fallthrough_c;
          trap_tval_d      = target_c;
        end
      end
      ST_REDIRECT: begin
        if (FLUSH_CYCLES == 1) begin
          state_d = ST_IDLE;
        end else begin
          state_d  = ST_SQUASH;
          sq_cnt_d = SQ_W'(FLUSH_CYCLES - 2);
          flush_d  = 1'b1;
        end
      end
      ST_SQUASH: begin
        if (sq_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          sq_cnt_d = sq_cnt_q - SQ_W'(1);
          flush_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      sq_cnt_q         <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_q          <= 1'b0;
      trap_q           <= 1'b0;
      trap_tval_q      <= '0;
    end else begin
      state_q          <= state_d;
      sq_cnt_q         <= sq_cnt_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_q          <= flush_d;
      trap_q           <= trap_d;
      trap_tval_q      <= trap_tval_d;
    end
  end

  assign redirect_valid  = redirect_valid_q;
  assign redirect_pc     = redirect_pc_q;
  assign flush           = flush_q;
  assign trap_misaligned = trap_q;
  assign trap_tval       = trap_tval_q;

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispredict_cnt_q, mispredict_cnt_d;

  // Misaligned-but-correctly-predicted transfers count as branches only.
  always_comb begin
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (resolve_c) begin
      branch_cnt_d = branch_cnt_q + CNT_W'(1);
      if (mispredict_c) begin
        mispredict_cnt_d = mispredict_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign branch_cnt     = branch_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;
`else
  localparam int unsigned unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed self-checking bench for branch_resolve (FLUSH_CYCLES=2, XLEN=32).
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, stall_in, ex_is_branch, ex_is_jump, ex_is_jalr;
  logic [31:0] cmp_out, ex_pc, ex_imm, ex_rs1, ex_pred_target;
  logic        ex_pred_taken;
  logic        redirect_valid, flush, trap_misaligned;
  logic [31:0] redirect_pc, trap_tval;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

`ifdef BRANCH_STATS_EN
  logic [31:0] branch_cnt, mispredict_cnt;
  logic        rv4, fl4, tr4;
  logic [31:0] rpc4, tval4;
  logic [3:0]  bcnt4, mcnt4;
`endif

  branch_resolve #(.XLEN(32), .FLUSH_CYCLES(2), .CNT_W(32)) u_dut (
    .clk             (clk),
    .rst             (rst),
    .ex_valid        (ex_valid),
    .stall_in        (stall_in),
    .ex_is_branch    (ex_is_branch),
    .ex_is_jump      (ex_is_jump),
    .ex_is_jalr      (ex_is_jalr),
    .cmp_out         (cmp_out),
    .ex_pc           (ex_pc),
    .ex_imm          (ex_imm),
    .ex_rs1          (ex_rs1),
    .ex_pred_taken   (ex_pred_taken),
    .ex_pred_target  (ex_pred_target),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .flush           (flush),
    .trap_misaligned (trap_misaligned),
    .trap_tval       (trap_tval)
`ifdef BRANCH_STATS_EN
    ,
    .branch_cnt      (branch_cnt),
    .mispredict_cnt  (mispredict_cnt)
`endif
  );

`ifdef BRANCH_STATS_EN
  // Narrow-counter copy to observe wrap at 2^CNT_W
  branch_resolve #(.XLEN(32), .FLUSH_CYCLES(2), .CNT_W(4)) u_dut4 (
    .clk             (clk),
    .rst             (rst),
    .ex_valid        (ex_valid),
    .stall_in        (stall_in),
    .ex_is_branch    (ex_is_branch),
    .ex_is_jump      (ex_is_jump),
    .ex_is_jalr      (ex_is_jalr),
    .cmp_out         (cmp_out),
    .ex_pc           (ex_pc),
    .ex_imm          (ex_imm),
    .ex_rs1          (ex_rs1),
    .ex_pred_taken   (ex_pred_taken),
    .ex_pred_target  (ex_pred_target),
    .redirect_valid  (rv4),
    .redirect_pc     (rpc4),
    .flush           (fl4),
    .trap_misaligned (tr4),
    .trap_tval       (tval4),
    .branch_cnt      (bcnt4),
    .mispredict_cnt  (mcnt4)
  );
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic br, input logic jmp, input logic jalr, input logic cmp,
                        input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1,
                        input logic pt, input logic [31:0] ptgt);
    ex_valid       = 1'b1;
    stall_in       = 1'b0;
    ex_is_branch   = br;
    ex_is_jump     = jmp;
    ex_is_jalr     = jalr;
    cmp_out        = {31'd0, cmp};
    ex_pc          = pc;
    ex_imm         = imm;
    ex_rs1         = rs1;
    ex_pred_taken  = pt;
    ex_pred_target = ptgt;
  endtask

  task automatic clr_ex();
    ex_valid     = 1'b0;
    stall_in     = 1'b0;
    ex_is_branch = 1'b0;
    ex_is_jump   = 1'b0;
    ex_is_jalr   = 1'b0;
  endtask

  task automatic fire(input logic br, input logic jmp, input logic jalr, input logic cmp,
                      input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1,
                      input logic pt, input logic [31:0] ptgt, input int wait_cyc);
    set_ex(br, jmp, jalr, cmp, pc, imm, rs1, pt, ptgt);
    step();
    clr_ex();
    repeat (wait_cyc) step();
  endtask

  initial begin
    rst = 1'b1;
    set_ex(0, 0, 0, 0, '0, '0, '0, 0, '0);
    clr_ex();
    repeat (2) step();
    chk("rst_rv",    32'(redirect_valid),  32'd0);
    chk("rst_rpc",   redirect_pc,          32'd0);
    chk("rst_flush", 32'(flush),           32'd0);
    chk("rst_trap",  32'(trap_misaligned), 32'd0);
    chk("rst_tval",  trap_tval,            32'd0);
    rst = 1'b0;
    step();

    // BEQ taken, predicted not-taken
    set_ex(1, 0, 0, 1, 32'h100, 32'h20, '0, 0, '0);
    step();
    clr_ex();
    chk("beq_rv",     32'(redirect_valid),  32'd1);
    chk("beq_rpc",    redirect_pc,          32'h120);
    chk("beq_flush1", 32'(flush),           32'd1);
    chk("beq_trap",   32'(trap_misaligned), 32'd0);
    step();
    chk("beq_flush2", 32'(flush),           32'd1);
    chk("beq_rv2",    32'(redirect_valid),  32'd0);
    step();
    chk("beq_flush3", 32'(flush),           32'd0);

    // Same BEQ, correctly predicted
    set_ex(1, 0, 0, 1, 32'h100, 32'h20, '0, 1, 32'h120);
    step();
    clr_ex();
    chk("ok_rv",    32'(redirect_valid),  32'd0);
    chk("ok_flush", 32'(flush),           32'd0);
    chk("ok_trap",  32'(trap_misaligned), 32'd0);

    // BNE not taken, predicted taken
    set_ex(1, 0, 0, 0, 32'h200, 32'h40, '0, 1, 32'h240);
    step();
    clr_ex();
    chk("bne_rv",  32'(redirect_valid), 32'd1);
    chk("bne_rpc", redirect_pc,         32'h204);
    repeat (2) step();

    // JALR: bit 0 of target cleared
    set_ex(0, 1, 1, 0, 32'h300, 32'h10, 32'h1001, 0, '0);
    step();
    clr_ex();
    chk("jalr_rv",   32'(redirect_valid),  32'd1);
    chk("jalr_rpc",  redirect_pc,          32'h1010);
    chk("jalr_trap", 32'(trap_misaligned), 32'd0);
    repeat (2) step();
    set_ex(0, 1, 1, 0, 32'h300, 32'h10, 32'h1001, 1, 32'h1010);
    step();
    clr_ex();
    chk("jalr_ok_rv",    32'(redirect_valid), 32'd0);
    chk("jalr_ok_flush", 32'(flush),          32'd0);

    // JAL to misaligned target, correctly predicted
    set_ex(0, 1, 0, 0, 32'h100, 32'h2, '0, 1, 32'h102);
    step();
    clr_ex();
    chk("mis_trap",  32'(trap_misaligned), 32'd1);
    chk("mis_tval",  trap_tval,            32'h102);
    chk("mis_rv",    32'(redirect_valid),  32'd0);
    chk("mis_flush", 32'(flush),           32'd1);
    step();
    chk("mis_trap2",  32'(trap_misaligned), 32'd0);
    chk("mis_flush2", 32'(flush),           32'd1);
    step();

    // Back-to-back mispredicts during REDIRECT/SQUASH are ignored
    set_ex(1, 0, 0, 1, 32'h400, 32'h8, '0, 0, '0);
    step();
    chk("b2b_rv1",  32'(redirect_valid), 32'd1);
    chk("b2b_rpc1", redirect_pc,         32'h408);
    set_ex(1, 0, 0, 1, 32'h500, 32'h10, '0, 0, '0);
    step();
    chk("b2b_rv2",    32'(redirect_valid), 32'd0);
    chk("b2b_flush2", 32'(flush),          32'd1);
    set_ex(1, 0, 0, 1, 32'h600, 32'h10, '0, 0, '0);
    step();
    chk("b2b_rv3",    32'(redirect_valid), 32'd0);
    chk("b2b_flush3", 32'(flush),          32'd0);
    set_ex(1, 0, 0, 1, 32'h700, 32'h10, '0, 0, '0);
    step();
    clr_ex();
    chk("b2b_rv4",  32'(redirect_valid), 32'd1);
    chk("b2b_rpc4", redirect_pc,         32'h710);
    repeat (2) step();

    // Stall holds off resolution
    set_ex(1, 0, 0, 1, 32'h800, 32'h20, '0, 0, '0);
    stall_in = 1'b1;
    step();
    chk("stall_rv1",    32'(redirect_valid), 32'd0);
    chk("stall_flush1", 32'(flush),          32'd0);
    step();
    chk("stall_rv2", 32'(redirect_valid), 32'd0);
    stall_in = 1'b0;
    step();
    clr_ex();
    chk("stall_rel_rv",  32'(redirect_valid), 32'd1);
    chk("stall_rel_rpc", redirect_pc,         32'h820);
    repeat (2) step();

    // Non-control and invalid instructions ignored
    set_ex(0, 0, 0, 1, 32'h900, 32'h20, '0, 1, 32'h1234);
    step();
    chk("nonctl_rv",    32'(redirect_valid), 32'd0);
    chk("nonctl_flush", 32'(flush),          32'd0);
    set_ex(1, 0, 0, 1, 32'h900, 32'h20, '0, 0, '0);
    ex_valid = 1'b0;
    step();
    clr_ex();
    chk("inval_rv",    32'(redirect_valid), 32'd0);
    chk("inval_flush", 32'(flush),          32'd0);

    // Fallthrough wraps at 2^32; then async reset mid-SQUASH
    set_ex(1, 0, 0, 0, 32'hFFFF_FFFC, 32'h10, '0, 1, 32'hC);
    step();
    clr_ex();
    chk("wrap_rv",   32'(redirect_valid), 32'd1);
    chk("wrap_rpc",  redirect_pc,         32'h0);
    chk("wrap_tval", trap_tval,           32'hC);
    step();
    chk("sq_flush", 32'(flush), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_flush", 32'(flush),          32'd0);
    chk("arst_rv",    32'(redirect_valid), 32'd0);
    chk("arst_rpc",   redirect_pc,         32'd0);
    chk("arst_tval",  trap_tval,           32'd0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_flush", 32'(flush), 32'd0);

`ifdef BRANCH_STATS_EN
    // 10 resolves: 3 mispredicts, 1 correctly predicted misaligned
    fire(1, 0, 0, 1, 32'h100, 32'h20, '0, 0, '0, 2);
    fire(1, 0, 0, 1, 32'h100, 32'h20, '0, 1, 32'h120, 0);
    fire(1, 0, 0, 0, 32'h200, 32'h40, '0, 0, '0, 0);
    fire(0, 1, 0, 0, 32'h100, 32'h40, '0, 1, 32'h140, 0);
    fire(1, 0, 0, 0, 32'h200, 32'h40, '0, 1, 32'h240, 2);
    fire(0, 1, 0, 0, 32'h100, 32'h2, '0, 1, 32'h102, 2);
    fire(0, 1, 1, 0, 32'h300, 32'h10, 32'h1001, 0, '0, 2);
    fire(1, 0, 0, 1, 32'h100, 32'h20, '0, 1, 32'h120, 0);
    fire(1, 0, 0, 0, 32'h200, 32'h40, '0, 0, '0, 0);
    fire(0, 1, 0, 0, 32'h100, 32'h40, '0, 1, 32'h140, 0);
    chk("stat_branch",   branch_cnt,        32'd10);
    chk("stat_mispred",  mispredict_cnt,    32'd3);
    chk("stat4_branch",  32'(bcnt4),        32'd10);
    for (int i = 0; i < 6; i++) begin
      fire(1, 0, 0, 1, 32'h100, 32'h20, '0, 1, 32'h120, 0);
    end
    chk("stat_branch16", branch_cnt,        32'd16);
    chk("stat4_wrap",    32'(bcnt4),        32'd0);
    chk("stat4_mispred", 32'(mcnt4),        32'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
